// File: rtl/alu_control_data_memory.sv
// Execute/memory slice of the 5-stage MIPS core: it decodes the instruction, runs the ALU and holds a word-addressed data memory.
// Optional feature: define MEM_ADDR_CHECK_EN to flag misaligned or out-of-range lw/sw addresses on mem_err.
module alu_control_data_memory #(
    parameter int unsigned DEPTH = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instr,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    output logic        jump,
    output logic        beq,
    output logic        mem_to_reg,
    output logic        mem_write,
    output logic        alu_src,
    output logic        reg_write,
    output logic        reg_dest,
    output logic [2:0]  alu_op,
    output logic [31:0] alu_out,
    output logic        zero,
    output logic        branch_taken,
    output logic [4:0]  wb_reg,
    output logic [31:0] mem_rdata,
    output logic [31:0] wb_data,
    output logic        mem_err
);

    localparam int unsigned AW = $clog2(DEPTH);

    typedef enum logic [2:0] {
        ALU_AND  = 3'b000,
        ALU_OR   = 3'b001,
        ALU_ADD  = 3'b010,
        ALU_XOR  = 3'b011,
        ALU_NOR  = 3'b100,
        ALU_SLTU = 3'b101,
        ALU_SUB  = 3'b110,
        ALU_SLT  = 3'b111
    } alu_sel_t;

    typedef enum logic [5:0] {
        OP_RTYPE = 6'b000000,
        OP_J     = 6'b000010,
        OP_BEQ   = 6'b000100,
        OP_ADDI  = 6'b001000,
        OP_SLTI  = 6'b001010,
        OP_ANDI  = 6'b001100,
        OP_ORI   = 6'b001101,
        OP_LW    = 6'b100011,
        OP_SW    = 6'b101011
    } opcode_t;

    alu_sel_t        sel;
    logic            zext;
    logic [31:0]     imm_ext;
    logic [31:0]     op_b;
    logic [AW-1:0]   mem_idx;
    logic [31:0]     mem [DEPTH];

    always_comb begin
        jump       = 1'b0;
        beq        = 1'b0;
        mem_to_reg = 1'b0;
        mem_write  = 1'b0;
        alu_src    = 1'b0;
        reg_write  = 1'b0;
        reg_dest   = 1'b0;
        zext       = 1'b0;
        sel        = ALU_ADD;
        case (instr[31:26])
            OP_RTYPE: begin
                reg_dest  = 1'b1;
                reg_write = 1'b1;
                case (instr[5:0])
                    6'b100000: sel = ALU_ADD;
                    6'b100010: sel = ALU_SUB;
                    6'b100100: sel = ALU_AND;
                    6'b100101: sel = ALU_OR;
                    6'b100110: sel = ALU_XOR;
                    6'b100111: sel = ALU_NOR;
                    6'b101010: sel = ALU_SLT;
                    6'b101011: sel = ALU_SLTU;
                    default:   reg_write = 1'b0;
                endcase
            end
            OP_LW: begin
                alu_src    = 1'b1;
                mem_to_reg = 1'b1;
                reg_write  = 1'b1;
            end
            OP_SW: begin
                alu_src   = 1'b1;
                mem_write = 1'b1;
            end
            OP_BEQ: begin
                beq = 1'b1;
                sel = ALU_SUB;
            end
            OP_J:    jump = 1'b1;
            OP_ADDI: begin
                alu_src   = 1'b1;
                reg_write = 1'b1;
            end
            OP_ANDI: begin
                alu_src   = 1'b1;
                reg_write = 1'b1;
                zext      = 1'b1;
                sel       = ALU_AND;
            end
            OP_ORI: begin
                alu_src   = 1'b1;
                reg_write = 1'b1;
                zext      = 1'b1;
                sel       = ALU_OR;
            end
            OP_SLTI: begin
                alu_src   = 1'b1;
                reg_write = 1'b1;
                sel       = ALU_SLT;
            end
            default: ;
        endcase
    end

    assign alu_op  = sel;
    assign imm_ext = zext ? {16'h0000, instr[15:0]} : {{16{instr[15]}}, instr[15:0]};
    assign op_b    = alu_src ? imm_ext : rt_data;

    always_comb begin
        alu_out = '0;
        case (sel)
            ALU_AND:  alu_out = rs_data & op_b;
            ALU_OR:   alu_out = rs_data | op_b;
            ALU_ADD:  alu_out = rs_data + op_b;
            ALU_XOR:  alu_out = rs_data ^ op_b;
            ALU_NOR:  alu_out = ~(rs_data | op_b);
            ALU_SLTU: alu_out = {31'd0, rs_data < op_b};
            ALU_SUB:  alu_out = rs_data - op_b;
            ALU_SLT:  alu_out = {31'd0, $signed(rs_data) < $signed(op_b)};
            default:  alu_out = '0;
        endcase
    end

    assign zero         = (alu_out == '0);
    assign branch_taken = beq & zero;
    assign wb_reg       = reg_dest ? instr[15:11] : instr[20:16];
    assign mem_idx      = alu_out[AW+1:2];

`ifdef MEM_ADDR_CHECK_EN
    assign mem_err   = (mem_write | mem_to_reg) &
                       ((alu_out[1:0] != 2'b00) | (|alu_out[31:AW+2]));
    assign mem_rdata = mem_err ? '0 : mem[mem_idx];
`else
    assign mem_err   = 1'b0;
    assign mem_rdata = mem[mem_idx];
`endif

    assign wb_data = mem_to_reg ? mem_rdata : alu_out;

    // Reset clears every word and takes priority over a concurrent store.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (mem_write && !mem_err) begin
            mem[mem_idx] <= rt_data;
        end
    end

endmodule

// File: tb/tb_alu_control_data_memory.sv
// Randomized self-checking bench for alu_control_data_memory against a behavioural MIPS EX/MEM model.
module tb_alu_control_data_memory;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] instr, rs_data, rt_data;
    logic        jump, beq, mem_to_reg, mem_write, alu_src, reg_write, reg_dest;
    logic [2:0]  alu_op;
    logic [31:0] alu_out, mem_rdata, wb_data;
    logic        zero, branch_taken, mem_err;
    logic [4:0]  wb_reg;

    alu_control_data_memory #(.DEPTH(256)) dut (
        .clk(clk), .rst(rst), .instr(instr), .rs_data(rs_data), .rt_data(rt_data),
        .jump(jump), .beq(beq), .mem_to_reg(mem_to_reg), .mem_write(mem_write),
        .alu_src(alu_src), .reg_write(reg_write), .reg_dest(reg_dest), .alu_op(alu_op),
        .alu_out(alu_out), .zero(zero), .branch_taken(branch_taken), .wb_reg(wb_reg),
        .mem_rdata(mem_rdata), .wb_data(wb_data), .mem_err(mem_err)
    );

    always #5 clk = ~clk;

    int unsigned total = 0;
    int unsigned bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference state: memory image plus the expected outputs for the current inputs.
    logic [31:0] ref_mem [256];
    logic [9:0]  e_ctrl;
    logic [31:0] e_alu, e_rdata, e_wb;
    logic        e_zero, e_bt, e_err, e_mw;
    logic [4:0]  e_wbreg;

    function automatic logic [31:0] ref_alu(input logic [2:0] code, input logic [31:0] a, input logic [31:0] b);
        case (code)
            3'd0: return a & b;
            3'd1: return a | b;
            3'd2: return a + b;
            3'd3: return a ^ b;
            3'd4: return ~(a | b);
            3'd5: return (a < b) ? 32'd1 : 32'd0;
            3'd6: return a - b;
            default: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
        endcase
    endfunction

    task automatic model();
        logic j, bq, m2r, mw, as, rw, rd;
        logic [2:0] aop;
        logic [31:0] imm, b;
        bit zx;
        {j, bq, m2r, mw, as, rw, rd} = '0;
        aop = 3'd2;
        zx  = 0;
        case (instr[31:26])
            6'h00: begin
                rd = 1; rw = 1;
                case (instr[5:0])
                    6'h20: aop = 3'd2;
                    6'h22: aop = 3'd6;
                    6'h24: aop = 3'd0;
                    6'h25: aop = 3'd1;
                    6'h26: aop = 3'd3;
                    6'h27: aop = 3'd4;
                    6'h2A: aop = 3'd7;
                    6'h2B: aop = 3'd5;
                    default: rw = 0;
                endcase
            end
            6'h23: begin as = 1; m2r = 1; rw = 1; end
            6'h2B: begin as = 1; mw = 1; end
            6'h04: begin bq = 1; aop = 3'd6; end
            6'h02: j = 1;
            6'h08: begin as = 1; rw = 1; end
            6'h0C: begin as = 1; rw = 1; aop = 3'd0; zx = 1; end
            6'h0D: begin as = 1; rw = 1; aop = 3'd1; zx = 1; end
            6'h0A: begin as = 1; rw = 1; aop = 3'd7; end
            default: ;
        endcase
        imm     = zx ? {16'h0, instr[15:0]} : {{16{instr[15]}}, instr[15:0]};
        b       = as ? imm : rt_data;
        e_ctrl  = {j, bq, m2r, mw, as, rw, rd, aop};
        e_mw    = mw;
        e_alu   = ref_alu(aop, rs_data, b);
        e_zero  = (e_alu == 32'd0);
        e_bt    = bq & e_zero;
        e_wbreg = rd ? instr[15:11] : instr[20:16];
`ifdef MEM_ADDR_CHECK_EN
        e_err   = (mw | m2r) && (e_alu[1:0] != 2'b00 || e_alu[31:10] != 22'd0);
`else
        e_err   = 1'b0;
`endif
        e_rdata = e_err ? 32'd0 : ref_mem[e_alu[9:2]];
        e_wb    = m2r ? e_rdata : e_alu;
    endtask

    task automatic drive(input logic [31:0] i, input logic [31:0] a, input logic [31:0] b, input logic r);
        instr = i; rs_data = a; rt_data = b; rst = r;
        #3;
        model();
        check("ctrl", {22'd0, jump, beq, mem_to_reg, mem_write, alu_src, reg_write, reg_dest, alu_op}, {22'd0, e_ctrl});
        check("alu_out", alu_out, e_alu);
        check("zero", {31'd0, zero}, {31'd0, e_zero});
        check("branch_taken", {31'd0, branch_taken}, {31'd0, e_bt});
        check("wb_reg", {27'd0, wb_reg}, {27'd0, e_wbreg});
        check("mem_err", {31'd0, mem_err}, {31'd0, e_err});
        check("mem_rdata", mem_rdata, e_rdata);
        check("wb_data", wb_data, e_wb);
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst) begin
            for (int k = 0; k < 256; k++) ref_mem[k] = 32'd0;
        end else if (e_mw && !e_err) begin
            ref_mem[e_alu[9:2]] = rt_data;
        end
        #1;
    endtask

    function automatic logic [31:0] r_type(input logic [4:0] s, input logic [4:0] t, input logic [4:0] d, input logic [5:0] f);
        return {6'h00, s, t, d, 5'd0, f};
    endfunction

    function automatic logic [31:0] i_type(input logic [5:0] op, input logic [4:0] s, input logic [4:0] t, input logic [15:0] im);
        return {op, s, t, im};
    endfunction

    logic [5:0] ops   [10] = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h02, 6'h08, 6'h0C, 6'h0D, 6'h0A, 6'h3F};
    logic [5:0] functs[8]  = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B};

    initial begin
        instr = '0; rs_data = '0; rt_data = '0; rst = 1'b1;
        @(posedge clk);
        for (int k = 0; k < 256; k++) ref_mem[k] = 32'd0;
        #1;

        // Post-reset reads
        drive(i_type(6'h23, 5'd1, 5'd2, 16'h0000), 32'h0, 32'h0, 1'b0);
        check("reset_read0", mem_rdata, 32'd0);
        tick();
        drive(i_type(6'h23, 5'd1, 5'd2, 16'h03FC), 32'h0, 32'h0, 1'b0);
        check("reset_read255", mem_rdata, 32'd0);
        tick();

        drive(r_type(5'd1, 5'd2, 5'd3, 6'h20), 32'd5, 32'd7, 1'b0);
        check("add_alu", alu_out, 32'd12);
        check("add_wbreg", {27'd0, wb_reg}, 32'd3);
        tick();
        drive(r_type(5'd1, 5'd2, 5'd3, 6'h22), 32'd9, 32'd9, 1'b0);
        check("sub_zero", {31'd0, zero}, 32'd1);
        tick();
        drive(i_type(6'h04, 5'd1, 5'd2, 16'h0010), 32'd9, 32'd9, 1'b0);
        check("beq_taken", {31'd0, branch_taken}, 32'd1);
        tick();
        drive(i_type(6'h0A, 5'd1, 5'd2, 16'hFFFF), 32'hFFFFFFFE, 32'd0, 1'b0);
        check("slti", alu_out, 32'd1);
        tick();
        drive(i_type(6'h0C, 5'd1, 5'd2, 16'h8000), 32'hFFFFFFFF, 32'd0, 1'b0);
        check("andi", alu_out, 32'h00008000);
        tick();

        drive(i_type(6'h2B, 5'd1, 5'd2, 16'h0004), 32'h10, 32'hDEADBEEF, 1'b0);
        check("sw_old_data", mem_rdata, 32'd0);
        tick();
        drive(i_type(6'h23, 5'd1, 5'd2, 16'h0004), 32'h10, 32'h0, 1'b0);
        check("lw_after_sw", wb_data, 32'hDEADBEEF);
        tick();

        drive(i_type(6'h2B, 5'd1, 5'd2, 16'h0008), 32'h10, 32'h12345678, 1'b1);
        tick();
        drive(i_type(6'h23, 5'd1, 5'd2, 16'h0008), 32'h10, 32'h0, 1'b0);
        check("rst_drops_write", mem_rdata, 32'd0);
        tick();
        drive(i_type(6'h23, 5'd1, 5'd2, 16'h0004), 32'h10, 32'h0, 1'b0);
        check("rst_clears", mem_rdata, 32'd0);
        tick();

        drive(32'hFFFF_FFFF, 32'd3, 32'd4, 1'b0);
        check("unknown_ctrl", {22'd0, jump, beq, mem_to_reg, mem_write, alu_src, reg_write, reg_dest, alu_op}, 32'h2);
        tick();

        drive(i_type(6'h2B, 5'd1, 5'd2, 16'h0000), 32'h402, 32'hCAFEF00D, 1'b0);
        tick();
        drive(i_type(6'h23, 5'd1, 5'd2, 16'h0000), 32'h0, 32'h0, 1'b0);
        tick();

        for (int n = 0; n < 400; n++) begin
            logic [5:0]  op;
            logic [31:0] ins, a, b;
            logic        r;
            op  = ops[$urandom_range(0, 9)];
            ins = {op, 26'($urandom)};
            if (op == 6'h00 && $urandom_range(0, 7) != 0) ins[5:0] = functs[$urandom_range(0, 7)];
            a = $urandom;
            b = $urandom;
            if ((op == 6'h23 || op == 6'h2B) && $urandom_range(0, 3) != 0) begin
                a = {22'd0, 8'($urandom), 2'b00};
                ins[15:0] = {9'd0, 5'($urandom), 2'b00};
            end
            if ($urandom_range(0, 3) == 0) b = a;
            r = ($urandom_range(0, 24) == 0);
            drive(ins, a, b, r);
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
